sr_reg_bank: RTL and testbench
==============================

# sr_reg_bank

Parametrised, clocked bank of WIDTH independent set/reset storage channels. It replaces free-running cross-coupled latches in the flip-flops-and-latches projects with a single synchronous block. The S=R conflict case is resolved by a selectable policy, and conflicts are logged through per-channel sticky flags and a saturating event counter. It feeds board LEDs and downstream control logic directly.

## Interface
Parameters:
- WIDTH, 4, number of independent channels (1..32)
- MODE, 1, S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- INIT, 0, WIDTH-bit reset value of q
- CNT_W, 8, width of conflict_cnt (2..16)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s  in  WIDTH  per-channel set request
- r  in  WIDTH  per-channel reset request
- en  in  1  global update enable
- clr_flags  in  1  synchronous clear of conflict and conflict_cnt
- q  out  WIDTH  stored state
- qn  out  WIDTH  always exactly ~q
- conflict  out  WIDTH  sticky per-channel flag: S=R=1 seen while enabled
- conflict_cnt  out  CNT_W  saturating count of cycles with ≥1 conflicting channel

## Operation
- Reset values (asserted asynchronously, held while rst=1):
  - q=INIT, qn=~INIT
  - conflict=0, conflict_cnt=0
  - edge-history registers =0
- Per channel i, on each rising clk edge with en=1, using the effective requests es[i] and er[i]:
  - 0/0: hold
  - 1/0: q=1
  - 0/1: q=0
  - 1/1: apply MODE. Hold keeps q, set-dominant gives q=1, reset-dominant gives q=0, toggle gives q=~q. Raise conflict[i].
- en=0: q, conflict and conflict_cnt all hold. Requests are ignored, not queued.
- conflict_cnt increments by 1 on each enabled cycle where any channel has es=er=1.
  - It is one event per cycle, regardless of how many channels conflict.
  - It saturates at 2^CNT_W−1 and never wraps.
- clr_flags=1 in the same cycle as a new conflict:
  - The clear applies first, then the new event.
  - Result: the affected conflict bits =1 and conflict_cnt=1. Events are never lost.
- clr_flags does not affect q.
- Channels are fully independent. There is no cross-channel priority.

## Timing
- Latency is one cycle. Inputs are sampled at rising edge N, and q/qn/flags show the result immediately after edge N.
- q and qn are both registered. qn is never derived combinationally from an unregistered path, and the two never disagree, including in the reset cycle.
- A rst assertion mid-operation forces all reset values immediately, without waiting for clk.
- After rst deasserts, the first rising edge performs a normal update.
- Inputs must be synchronous to clk. The block contains no input synchronisers; board switches go through the existing debouncer first.

## Configuration
- SR_BANK_EDGE_EN
  - Defined: es[i] = s[i] & ~s_prev[i] and er[i] = r[i] & ~r_prev[i]. Only rising edges act, so a held request acts exactly once.
    - s_prev and r_prev update on every clk edge, including when en=0. Edges occurring while disabled are discarded.
    - Because the history resets to 0, an input already high at the first post-reset edge counts as an edge.
    - Conflict requires both rising edges in the same cycle.
  - Undefined: es=s and er=r (level-sensitive). No history registers are instantiated.
- Latency is one cycle in both builds.

## Structure
- The shared package sr_bank_pkg holds:
  - MODE_HOLD=0, MODE_SET_DOM=1, MODE_RST_DOM=2, MODE_TOGGLE=3
  - the sr_mode_t typedef
- Sub-module sr_cell:
  - One channel's next-state function, parametrised by MODE.
  - Outputs: next q and a conflict strobe.
  - Instantiated WIDTH times in a generate loop.
- Top level owns the edge-history registers, the sticky flags and the counter.

## Test plan
- Reset, WIDTH=4, INIT=4'b1010: assert rst mid-cycle → q=1010 and qn=0101 immediately, flags=0, cnt=0. Hold s=1111 through reset release → q=1111 one edge later.
- MODE=1,2,3 separately: drive s[0]=r[0]=1 for 3 cycles, starting from q[0]=0.
  - Set-dominant: q[0]=1.
  - Reset-dominant: q[0]=0.
  - Toggle: q[0] goes 1,0,1.
  - In every mode: conflict[0]=1, cnt=3.
- CNT_W=2: 5 conflicting enabled cycles → cnt goes 1,2,3,3,3. Then clr_flags alone → cnt=0 and conflict=0.
- clr_flags together with a conflict on channel 2 → conflict=0100, cnt=1.
- en=0 with s=1111 → q unchanged and cnt unchanged. Set en=1 the next cycle → q=1111. With SR_BANK_EDGE_EN defined, q is instead unchanged, because the edge occurred while disabled.
- SR_BANK_EDGE_EN defined, MODE=3: hold s[1]=r[1]=1 for 4 cycles → q[1] toggles once, cnt=1.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared types and constants for the set/reset storage bank.
// Policy codes for the S=R=1 conflict case live here.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'd0,
        MODE_SET_DOM = 2'd1,
        MODE_RST_DOM = 2'd2,
        MODE_TOGGLE  = 2'd3
    } sr_mode_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;
    localparam int CNT_W_MIN = 2;
    localparam int CNT_W_MAX = 16;

    // Map an integer parameter onto the policy enum.
    function automatic sr_mode_t to_mode(input int m);
        return sr_mode_t'(m[1:0]);
    endfunction

endpackage

// File: rtl/sr_cell.sv
// Next-state function of a single set/reset channel.
// MODE selects what happens when set and reset are both requested.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter sr_mode_t MODE = MODE_SET_DOM
) (
    input  logic q_i,
    input  logic es_i,
    input  logic er_i,
    output logic q_next_o,
    output logic conflict_o
);

    // Resolve the request pair into the channel's next value.
    always_comb begin
        q_next_o   = q_i;
        conflict_o = 1'b0;
        unique case ({es_i, er_i})
            2'b10: q_next_o = 1'b1;
            2'b01: q_next_o = 1'b0;
            2'b11: begin
                conflict_o = 1'b1;
                unique case (MODE)
                    MODE_HOLD:    q_next_o = q_i;
                    MODE_SET_DOM: q_next_o = 1'b1;
                    MODE_RST_DOM: q_next_o = 1'b0;
                    MODE_TOGGLE:  q_next_o = ~q_i;
                    default:      q_next_o = q_i;
                endcase
            end
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/sr_reg_bank.sv
// Clocked bank of independent set/reset channels with conflict logging.
// Optional macro SR_BANK_EDGE_EN makes requests rising-edge sensitive.
module sr_reg_bank
    import sr_bank_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               MODE  = 1,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             en,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam sr_mode_t         POLICY  = to_mode(MODE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] es;
    logic [WIDTH-1:0] er;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] cfl;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qn_q, qn_d;
    logic [WIDTH-1:0] conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SR_BANK_EDGE_EN
    logic [WIDTH-1:0] s_prev_q, s_prev_d;
    logic [WIDTH-1:0] r_prev_q, r_prev_d;

    // History tracks inputs every edge, even when disabled.
    always_comb begin
        s_prev_d = s;
        r_prev_d = r;
    end

    // Request history registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev_q <= '0;
            r_prev_q <= '0;
        end else begin
            s_prev_q <= s_prev_d;
            r_prev_q <= r_prev_d;
        end
    end

    assign es = s & ~s_prev_q;
    assign er = r & ~r_prev_q;
`else
    assign es = s;
    assign er = r;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE (POLICY)
        ) u_cell (
            .q_i        (q_q[i]),
            .es_i       (es[i]),
            .er_i       (er[i]),
            .q_next_o   (q_nxt[i]),
            .conflict_o (cfl[i])
        );
    end

    // Clear first, then fold in this cycle's state and conflict event.
    always_comb begin
        q_d        = q_q;
        qn_d       = qn_q;
        conflict_d = conflict_q;
        cnt_d      = cnt_q;
        if (clr_flags) begin
            conflict_d = '0;
            cnt_d      = '0;
        end
        if (en) begin
            q_d        = q_nxt;
            qn_d       = ~q_nxt;
            conflict_d = conflict_d | cfl;
            if ((|cfl) && (cnt_d != CNT_MAX)) begin
                cnt_d = cnt_d + CNT_ONE;
            end
        end
    end

    // State, complement, sticky flags and event counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= INIT;
            qn_q       <= ~INIT;
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            qn_q       <= qn_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q            = q_q;
    assign qn           = qn_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: four instances with different policies.
// Expectations adapt when SR_BANK_EDGE_EN is defined.
module tb_sr_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;
    logic       en;
    logic       clr;

    logic [3:0] q1, qn1, c1;
    logic [3:0] q2, qn2, c2;
    logic [3:0] q3, qn3, c3;
    logic [3:0] q4, qn4, c4;
    logic [7:0] cnt1, cnt2, cnt3;
    logic [1:0] cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    int e3[5];
    int ec8[5];
    int ec2[5];

    always #5 clk = ~clk;

    sr_reg_bank #(.WIDTH(4), .MODE(1), .INIT(4'b1010), .CNT_W(8)) u_set (
        .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr_flags(clr),
        .q(q1), .qn(qn1), .conflict(c1), .conflict_cnt(cnt1)
    );
    sr_reg_bank #(.WIDTH(4), .MODE(2), .INIT(4'b1010), .CNT_W(8)) u_rst (
        .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr_flags(clr),
        .q(q2), .qn(qn2), .conflict(c2), .conflict_cnt(cnt2)
    );
    sr_reg_bank #(.WIDTH(4), .MODE(3), .INIT(4'b1010), .CNT_W(8)) u_tgl (
        .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr_flags(clr),
        .q(q3), .qn(qn3), .conflict(c3), .conflict_cnt(cnt3)
    );
    sr_reg_bank #(.WIDTH(4), .MODE(0), .INIT(4'b1010), .CNT_W(2)) u_hold (
        .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr_flags(clr),
        .q(q4), .qn(qn4), .conflict(c4), .conflict_cnt(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [3:0] qv,
                         input logic [3:0] qnv, input logic [3:0] exp);
        logic [3:0] nexp;
        nexp = ~exp;
        chk({tag, ".q"}, 32'(qv), 32'(exp));
        chk({tag, ".qn"}, 32'(qnv), 32'(nexp));
    endtask

    task automatic drive(input logic [3:0] sv, input logic [3:0] rv,
                         input logic ev, input logic cv);
        @(negedge clk);
        s   = sv;
        r   = rv;
        en  = ev;
        clr = cv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef SR_BANK_EDGE_EN
        e3  = '{1, 1, 1, 1, 1};
        ec8 = '{1, 1, 1, 1, 1};
        ec2 = '{1, 1, 1, 1, 1};
`else
        e3  = '{1, 0, 1, 0, 1};
        ec8 = '{1, 2, 3, 4, 5};
        ec2 = '{1, 2, 3, 3, 3};
`endif
        rst = 1'b1;
        s   = 4'hF;
        r   = 4'h0;
        en  = 1'b1;
        clr = 1'b0;

        #1;
        chk_q("rst0_d1", q1, qn1, 4'b1010);
        chk_q("rst0_d4", q4, qn4, 4'b1010);
        chk("rst0_c1", 32'(c1), 32'h0);
        chk("rst0_cnt1", 32'(cnt1), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        step();
        chk_q("rel_d1", q1, qn1, 4'b1111);
        chk_q("rel_d3", q3, qn3, 4'b1111);

        #2;
        rst = 1'b1;
        #1;
        chk_q("midrst_d1", q1, qn1, 4'b1010);
        chk_q("midrst_d2", q2, qn2, 4'b1010);
        chk("midrst_c1", 32'(c1), 32'h0);
        chk("midrst_cnt4", 32'(cnt4), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        step();
        chk_q("rel2_d1", q1, qn1, 4'b1111);

        drive(4'b0000, 4'b0001, 1'b1, 1'b0);
        step();
        chk_q("clr0_d1", q1, qn1, 4'b1110);
        chk_q("clr0_d4", q4, qn4, 4'b1110);

        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        step();
        chk_q("idle_d2", q2, qn2, 4'b1110);
        chk("idle_cnt1", 32'(cnt1), 32'h0);

        drive(4'b0001, 4'b0001, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_q($sformatf("cf%0d_set", k), q1, qn1, 4'b1111);
            chk_q($sformatf("cf%0d_rst", k), q2, qn2, 4'b1110);
            chk_q($sformatf("cf%0d_tgl", k), q3, qn3,
                  {3'b111, 1'(e3[k])});
            chk_q($sformatf("cf%0d_hold", k), q4, qn4, 4'b1110);
            chk($sformatf("cf%0d_c1", k), 32'(c1), 32'h1);
            chk($sformatf("cf%0d_c2", k), 32'(c2), 32'h1);
            chk($sformatf("cf%0d_c3", k), 32'(c3), 32'h1);
            chk($sformatf("cf%0d_c4", k), 32'(c4), 32'h1);
            chk($sformatf("cf%0d_cnt1", k), 32'(cnt1), 32'(ec8[k]));
            chk($sformatf("cf%0d_cnt3", k), 32'(cnt3), 32'(ec8[k]));
            chk($sformatf("cf%0d_cnt4", k), 32'(cnt4), 32'(ec2[k]));
        end

        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        step();
        chk("clr_c1", 32'(c1), 32'h0);
        chk("clr_cnt1", 32'(cnt1), 32'h0);
        chk("clr_c4", 32'(c4), 32'h0);
        chk("clr_cnt4", 32'(cnt4), 32'h0);
        chk_q("clr_q_d1", q1, qn1, 4'b1111);

        drive(4'b0100, 4'b0100, 1'b1, 1'b1);
        step();
        chk("clrev_c1", 32'(c1), 32'h4);
        chk("clrev_cnt1", 32'(cnt1), 32'h1);
        chk("clrev_c4", 32'(c4), 32'h4);
        chk("clrev_cnt4", 32'(cnt4), 32'h1);
        chk_q("clrev_d1", q1, qn1, 4'b1111);
        chk_q("clrev_d2", q2, qn2, 4'b1010);
        chk_q("clrev_d3", q3, qn3, 4'b1011);

        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        step();
        drive(4'b0000, 4'b1111, 1'b1, 1'b0);
        step();
        chk_q("rall_d1", q1, qn1, 4'b0000);
        chk_q("rall_d3", q3, qn3, 4'b0000);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        step();

        drive(4'b1111, 4'b0000, 1'b0, 1'b0);
        step();
        chk_q("dis_d1", q1, qn1, 4'b0000);
        chk("dis_cnt1", 32'(cnt1), 32'h1);
        chk("dis_c1", 32'(c1), 32'h4);

        drive(4'b1111, 4'b0000, 1'b1, 1'b0);
        step();
`ifdef SR_BANK_EDGE_EN
        chk_q("ena_d1", q1, qn1, 4'b0000);
`else
        chk_q("ena_d1", q1, qn1, 4'b1111);
`endif
        chk("ena_cnt1", 32'(cnt1), 32'h1);

        drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        step();
        chk("discf_cnt1", 32'(cnt1), 32'h1);
        chk("discf_c1", 32'(c1), 32'h4);
        chk("discf_cnt4", 32'(cnt4), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
